turn_light_monitor: RTL and testbench

- Passive checker on the tail-light lamp bus driven by the turn-signal sequencer.
- Watches the two 3-bit lamp vectors and reconstructs the turn command: left or right sweep in progress, and completed sweep counts.
- Flags illegal lamp patterns, illegal pattern transitions and stuck lamps.
- Sits beside the sequencer on the same clock and feeds status LEDs and the fault indicator.

---
 rtl/car_light_pkg.sv | 53 +++++
 rtl/sat_counter.sv | 29 ++
 rtl/turn_light_monitor.sv | 182 ++++++++++++++++++
 tb/tb_turn_light_monitor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/car_light_pkg.sv
// rtl/car_light_pkg.sv - shared tail-light lamp patterns, monitor states and fault codes
//
// Lamp patterns are packed as {l, r}; the left vector grows outward from bit0
// and the right vector grows outward from bit2. The turn-signal sequencer can
// share these constants with the monitor.
package car_light_pkg;

  typedef logic [5:0] lamp_t;

  localparam lamp_t PAT_IDLE = 6'b000_000;
  localparam lamp_t PAT_R1   = 6'b000_100;
  localparam lamp_t PAT_R2   = 6'b000_110;
  localparam lamp_t PAT_R3   = 6'b000_111;
  localparam lamp_t PAT_L1   = 6'b001_000;
  localparam lamp_t PAT_L2   = 6'b011_000;
  localparam lamp_t PAT_L3   = 6'b111_000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_R1    = 3'd1,
    ST_R2    = 3'd2,
    ST_R3    = 3'd3,
    ST_L1    = 3'd4,
    ST_L2    = 3'd5,
    ST_L3    = 3'd6,
    ST_FAULT = 3'd7
  } mon_state_t;

  localparam logic [1:0] FC_NONE       = 2'b00;
  localparam logic [1:0] FC_PATTERN    = 2'b01;
  localparam logic [1:0] FC_TRANSITION = 2'b10;
  localparam logic [1:0] FC_STUCK      = 2'b11;

  // Lamp pattern expected while sitting in a given state. FAULT has no
  // pattern of its own; it maps to IDLE, and the FSM never uses it there.
  function automatic lamp_t state_pattern(input mon_state_t s);
    case (s)
      ST_R1:   return PAT_R1;
      ST_R2:   return PAT_R2;
      ST_R3:   return PAT_R3;
      ST_L1:   return PAT_L1;
      ST_L2:   return PAT_L2;
      ST_L3:   return PAT_L3;
      default: return PAT_IDLE;
    endcase
  endfunction

  function automatic logic pattern_legal(input lamp_t p);
    return (p == PAT_IDLE) || (p == PAT_R1) || (p == PAT_R2) || (p == PAT_R3) ||
           (p == PAT_L1) || (p == PAT_L2) || (p == PAT_L3);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high reset
//   inc    in  count up by one (held at all-ones once reached)
//   clear  in  synchronous clear, wins over inc
//   q      out counter value
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/turn_light_monitor.sv
// rtl/turn_light_monitor.sv - passive checker on the turn-signal tail-light lamp bus
//
// Ports:
//   clk         in  system clock
//   reset       in  asynchronous, active-high reset
//   l[2:0]      in  left lamp vector (bit0 innermost)
//   r[2:0]      in  right lamp vector (bit2 innermost)
//   fault_clr   in  one-cycle pulse clearing the sticky fault
//   left_on     out left sweep in progress
//   right_on    out right sweep in progress
//   sweep_done  out one-cycle pulse on sweep completion
//   sweep_l     out completed left sweeps, saturating
//   sweep_r     out completed right sweeps, saturating
//   fault       out sticky fault flag
//   fault_code  out 00 none, 01 illegal pattern, 10 illegal transition, 11 stuck
module turn_light_monitor
  import car_light_pkg::*;
#(
  parameter int STUCK_MAX = 268435456,
  parameter int DWELL_W   = 29,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       l,
  input  logic [2:0]       r,
  input  logic             fault_clr,
  output logic             left_on,
  output logic             right_on,
  output logic             sweep_done,
  output logic [CNT_W-1:0] sweep_l,
  output logic [CNT_W-1:0] sweep_r,
  output logic             fault,
  output logic [1:0]       fault_code
);

  // The stuck fault fires in the cycle whose edge would bring dwell up to
  // STUCK_MAX, so FAULT is entered exactly STUCK_MAX cycles after state entry.
  localparam logic [DWELL_W-1:0] STUCK_LAST = DWELL_W'(STUCK_MAX - 1);

  lamp_t              in_q;
  mon_state_t         state;
  mon_state_t         state_next;
  logic [1:0]         ev_code;
  logic               done_l;
  logic               done_r;
  logic               dwell_clear;
  logic [DWELL_W-1:0] dwell;
  logic               left_on_d;
  logic               right_on_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q <= PAT_IDLE;
    end else begin
      in_q <= {l, r};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ev_code    = FC_NONE;
    done_l     = 1'b0;
    done_r     = 1'b0;
    if (state == ST_FAULT) begin
      if (in_q == PAT_IDLE) state_next = ST_IDLE;
    end else if (in_q != state_pattern(state)) begin
      if (!pattern_legal(in_q)) begin
        ev_code    = FC_PATTERN;
        state_next = ST_FAULT;
      end else begin
        case (state)
          ST_IDLE: begin
            if (in_q == PAT_R1)      state_next = ST_R1;
            else if (in_q == PAT_L1) state_next = ST_L1;
          end
          ST_R1: begin
            if (in_q == PAT_R2)        state_next = ST_R2;
            else if (in_q == PAT_IDLE) state_next = ST_IDLE;
          end
          ST_R2: begin
            if (in_q == PAT_R3)        state_next = ST_R3;
            else if (in_q == PAT_IDLE) state_next = ST_IDLE;
          end
          ST_R3: begin
            if (in_q == PAT_IDLE) begin
              state_next = ST_IDLE;
              done_r     = 1'b1;
            end
          end
          ST_L1: begin
            if (in_q == PAT_L2)        state_next = ST_L2;
            else if (in_q == PAT_IDLE) state_next = ST_IDLE;
          end
          ST_L2: begin
            if (in_q == PAT_L3)        state_next = ST_L3;
            else if (in_q == PAT_IDLE) state_next = ST_IDLE;
          end
          ST_L3: begin
            if (in_q == PAT_IDLE) begin
              state_next = ST_IDLE;
              done_l     = 1'b1;
            end
          end
          default: ;
        endcase
        // A legal pattern that differs from the current one but matched no
        // allowed successor leaves state_next untouched.
        if (state_next == state) begin
          ev_code    = FC_TRANSITION;
          state_next = ST_FAULT;
        end
      end
    end else if ((state != ST_IDLE) && (dwell == STUCK_LAST)) begin
      ev_code    = FC_STUCK;
      state_next = ST_FAULT;
    end
  end

  always_comb begin
    left_on_d  = state_next inside {ST_L1, ST_L2, ST_L3};
    right_on_d = state_next inside {ST_R1, ST_R2, ST_R3};
  end

  assign dwell_clear = (state_next != state) || (state == ST_IDLE) || (state == ST_FAULT);

  sat_counter #(.WIDTH(DWELL_W)) u_dwell (
    .clk   (clk),
    .reset (reset),
    .inc   (!dwell_clear),
    .clear (dwell_clear),
    .q     (dwell)
  );

  sat_counter #(.WIDTH(CNT_W)) u_sweep_l (
    .clk   (clk),
    .reset (reset),
    .inc   (done_l),
    .clear (1'b0),
    .q     (sweep_l)
  );

  sat_counter #(.WIDTH(CNT_W)) u_sweep_r (
    .clk   (clk),
    .reset (reset),
    .inc   (done_r),
    .clear (1'b0),
    .q     (sweep_r)
  );

  // A new fault event alongside fault_clr re-arms the latch with the new code;
  // otherwise only the first fault since the last clear is remembered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_on    <= 1'b0;
      right_on   <= 1'b0;
      sweep_done <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      left_on    <= left_on_d;
      right_on   <= right_on_d;
      sweep_done <= done_l | done_r;
      if ((ev_code != FC_NONE) && (!fault || fault_clr)) begin
        fault      <= 1'b1;
        fault_code <= ev_code;
      end else if ((ev_code == FC_NONE) && fault_clr) begin
        fault      <= 1'b0;
        fault_code <= FC_NONE;
      end
    end
  end

endmodule

// File: tb/tb_turn_light_monitor.sv
// tb/tb_turn_light_monitor.sv - directed self-checking bench for turn_light_monitor
module tb_turn_light_monitor;

  localparam logic [5:0] P_IDLE = 6'b000_000;
  localparam logic [5:0] P_R1   = 6'b000_100;
  localparam logic [5:0] P_R2   = 6'b000_110;
  localparam logic [5:0] P_R3   = 6'b000_111;
  localparam logic [5:0] P_L1   = 6'b001_000;
  localparam logic [5:0] P_L2   = 6'b011_000;
  localparam logic [5:0] P_L3   = 6'b111_000;
  localparam logic [5:0] P_BAD  = 6'b001_100;
  localparam logic [5:0] P_ALL  = 6'b111_111;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] l;
  logic [2:0] r;
  logic       fault_clr;

  // Instance a: long stuck limit, 8-bit counters. Instance b: STUCK_MAX=10, CNT_W=2.
  logic       a_left_on, a_right_on, a_done, a_fault;
  logic [7:0] a_sweep_l, a_sweep_r;
  logic [1:0] a_code;
  logic       b_left_on, b_right_on, b_done, b_fault;
  logic [1:0] b_sweep_l, b_sweep_r;
  logic [1:0] b_code;

  int checks = 0;
  int passed = 0;
  int done_a = 0;
  int done_b = 0;

  turn_light_monitor #(.STUCK_MAX(50), .DWELL_W(29), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .l(l), .r(r), .fault_clr(fault_clr),
    .left_on(a_left_on), .right_on(a_right_on), .sweep_done(a_done),
    .sweep_l(a_sweep_l), .sweep_r(a_sweep_r), .fault(a_fault), .fault_code(a_code)
  );

  turn_light_monitor #(.STUCK_MAX(10), .DWELL_W(29), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .l(l), .r(r), .fault_clr(fault_clr),
    .left_on(b_left_on), .right_on(b_right_on), .sweep_done(b_done),
    .sweep_l(b_sweep_l), .sweep_r(b_sweep_r), .fault(b_fault), .fault_code(b_code)
  );

  always #5 clk = ~clk;

  // Advance n falling edges, tallying sweep_done pulses seen on each.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      done_a += int'(a_done);
      done_b += int'(b_done);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fault_clr = 1'b0;
    {l, r} = P_IDLE;
    tick(2);
    reset = 1'b0;
    tick(1);
    done_a = 0;
    done_b = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fault_clr = 1'b0;
    {l, r} = P_IDLE;
    #1;
    checks++;
    if ({a_left_on, a_right_on, a_done, a_sweep_l, a_sweep_r, a_fault, a_code} !== 23'd0)
      $display("FAIL reset_outputs_a: got %b want 0", {a_left_on, a_right_on, a_done, a_sweep_l, a_sweep_r, a_fault, a_code});
    else passed++;
    checks++;
    if ({b_left_on, b_right_on, b_done, b_sweep_l, b_sweep_r, b_fault, b_code} !== 11'd0)
      $display("FAIL reset_outputs_b: got %b want 0", {b_left_on, b_right_on, b_done, b_sweep_l, b_sweep_r, b_fault, b_code});
    else passed++;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_right_sweep();
    do_reset();
    {l, r} = P_R1;
    tick(1);
    checks++; if (a_right_on !== 1'b0) $display("FAIL right_on_edge1: got %b want 0", a_right_on); else passed++;
    tick(1);
    checks++; if (a_right_on !== 1'b1) $display("FAIL right_on_edge2: got %b want 1", a_right_on); else passed++;
    tick(18);
    {l, r} = P_R2; tick(20);
    {l, r} = P_R3; tick(20);
    {l, r} = P_IDLE;
    tick(1);
    checks++; if (a_right_on !== 1'b1) $display("FAIL right_on_hold_end: got %b want 1", a_right_on); else passed++;
    tick(1);
    checks++; if (a_right_on !== 1'b0) $display("FAIL right_on_off: got %b want 0", a_right_on); else passed++;
    checks++; if (a_sweep_r !== 8'd1) $display("FAIL right_sweep_count: got %0d want 1", a_sweep_r); else passed++;
    tick(3);
    checks++; if (done_a !== 1) $display("FAIL right_done_pulses: got %0d want 1", done_a); else passed++;
    checks++; if (a_fault !== 1'b0) $display("FAIL right_no_fault: got %b want 0", a_fault); else passed++;
  endtask

  task automatic test_left_abort();
    do_reset();
    {l, r} = P_L1; tick(20);
    {l, r} = P_L2; tick(20);
    {l, r} = P_IDLE;
    tick(1);
    checks++; if (a_left_on !== 1'b1) $display("FAIL left_on_abort_edge1: got %b want 1", a_left_on); else passed++;
    tick(1);
    checks++; if (a_left_on !== 1'b0) $display("FAIL left_on_abort_edge2: got %b want 0", a_left_on); else passed++;
    checks++; if (a_sweep_l !== 8'd0) $display("FAIL left_abort_count: got %0d want 0", a_sweep_l); else passed++;
    {l, r} = P_L1; tick(5);
    {l, r} = P_L2; tick(5);
    {l, r} = P_L3; tick(5);
    {l, r} = P_IDLE; tick(3);
    checks++; if (a_sweep_l !== 8'd1) $display("FAIL left_sweep_count: got %0d want 1", a_sweep_l); else passed++;
    checks++; if (done_a !== 1) $display("FAIL left_done_pulses: got %0d want 1", done_a); else passed++;
    checks++; if (a_fault !== 1'b0) $display("FAIL left_no_fault: got %b want 0", a_fault); else passed++;
  endtask

  task automatic test_fault_pattern();
    do_reset();
    {l, r} = P_BAD; tick(3);
    checks++; if ({a_fault, a_code} !== 3'b1_01) $display("FAIL illegal_pattern: got %b want 101", {a_fault, a_code}); else passed++;
    {l, r} = P_IDLE; tick(3);
    fault_clr = 1'b1; tick(1);
    fault_clr = 1'b0; tick(1);
    checks++; if ({a_fault, a_code} !== 3'b0_00) $display("FAIL fault_clr: got %b want 000", {a_fault, a_code}); else passed++;
    {l, r} = P_R1; tick(3);
    checks++; if (a_right_on !== 1'b1) $display("FAIL fault_exit_r1: got %b want 1", a_right_on); else passed++;
    {l, r} = P_R3; tick(3);
    checks++; if ({a_fault, a_code} !== 3'b1_10) $display("FAIL illegal_transition: got %b want 110", {a_fault, a_code}); else passed++;
    checks++; if (a_right_on !== 1'b0) $display("FAIL fault_right_off: got %b want 0", a_right_on); else passed++;
    {l, r} = P_IDLE; tick(3);
    {l, r} = P_R1; tick(3);
    checks++; if (a_right_on !== 1'b1) $display("FAIL fault_to_idle_r1: got %b want 1", a_right_on); else passed++;
    checks++; if ({a_fault, a_code} !== 3'b1_10) $display("FAIL fault_sticky: got %b want 110", {a_fault, a_code}); else passed++;
  endtask

  task automatic test_stuck();
    do_reset();
    {l, r} = P_R1;
    tick(11);
    checks++; if (b_fault !== 1'b0) $display("FAIL stuck_early: got %b want 0", b_fault); else passed++;
    tick(1);
    checks++; if ({b_fault, b_code} !== 3'b1_11) $display("FAIL stuck_exact: got %b want 111", {b_fault, b_code}); else passed++;
    checks++; if ({b_right_on, b_left_on} !== 2'b00) $display("FAIL stuck_lamps_off: got %b want 00", {b_right_on, b_left_on}); else passed++;
    tick(3);
    {l, r} = P_ALL; tick(3);
    checks++; if ({b_fault, b_code} !== 3'b1_11) $display("FAIL stuck_not_overwritten: got %b want 111", {b_fault, b_code}); else passed++;
  endtask

  task automatic test_clr_collision();
    do_reset();
    {l, r} = P_R2; tick(3);
    checks++; if ({a_fault, a_code} !== 3'b1_10) $display("FAIL collide_setup: got %b want 110", {a_fault, a_code}); else passed++;
    {l, r} = P_IDLE; tick(3);
    {l, r} = P_BAD;
    tick(1);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    checks++; if ({a_fault, a_code} !== 3'b1_01) $display("FAIL clr_with_new_fault: got %b want 101", {a_fault, a_code}); else passed++;
  endtask

  task automatic test_reset_mid_sweep();
    do_reset();
    {l, r} = P_R1; tick(3);
    {l, r} = P_R2; tick(3);
    {l, r} = P_R3; tick(3);
    {l, r} = P_IDLE; tick(3);
    checks++; if (a_sweep_r !== 8'd1) $display("FAIL mid_setup_count: got %0d want 1", a_sweep_r); else passed++;
    {l, r} = P_R1; tick(3);
    {l, r} = P_R2; tick(3);
    checks++; if (a_right_on !== 1'b1) $display("FAIL mid_r2_on: got %b want 1", a_right_on); else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({a_left_on, a_right_on, a_done, a_sweep_l, a_sweep_r, a_fault, a_code} !== 23'd0)
      $display("FAIL async_reset_outputs: got %b want 0", {a_left_on, a_right_on, a_done, a_sweep_l, a_sweep_r, a_fault, a_code});
    else passed++;
    tick(1);
    reset = 1'b0;
    tick(3);
    checks++; if ({a_fault, a_code} !== 3'b1_10) $display("FAIL r2_after_reset: got %b want 110", {a_fault, a_code}); else passed++;
    checks++; if (a_right_on !== 1'b0) $display("FAIL r2_after_reset_on: got %b want 0", a_right_on); else passed++;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      {l, r} = P_R1; tick(3);
      {l, r} = P_R2; tick(3);
      {l, r} = P_R3; tick(3);
      {l, r} = P_IDLE; tick(3);
      if (i == 2) begin
        checks++; if (b_sweep_r !== 2'd3) $display("FAIL sat_reach: got %0d want 3", b_sweep_r); else passed++;
      end
    end
    checks++; if (b_sweep_r !== 2'd3) $display("FAIL sat_hold: got %0d want 3", b_sweep_r); else passed++;
    checks++; if (done_b !== 5) $display("FAIL sat_done_pulses: got %0d want 5", done_b); else passed++;
    checks++; if (a_sweep_r !== 8'd5) $display("FAIL wide_count: got %0d want 5", a_sweep_r); else passed++;
    checks++; if ({b_fault, b_sweep_l} !== 3'b0_00) $display("FAIL sat_side: got %b want 000", {b_fault, b_sweep_l}); else passed++;
  endtask

  initial begin
    test_reset();
    test_right_sweep();
    test_left_abort();
    test_fault_pattern();
    test_stuck();
    test_clr_collision();
    test_reset_mid_sweep();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
